// File: rtl/bram_frame_writer.sv
// Subsamples an RGB444 pixel stream and writes it into a BRAM frame buffer,
// frame-aligned on frame_done and flagging frames of the wrong size.
module bram_frame_writer #(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int DECIM  = 2,
   parameter int ADDR_W = 17
) (
   input  logic              p_clock,
   input  logic              rst,
   input  logic [11:0]       pixel_data,
   input  logic              pixel_valid,
   input  logic              frame_done,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [11:0]       wr_data,
   output logic              frame_ready,
   output logic              frame_err,
   output logic [7:0]        frame_cnt,
   output logic [1:0]        fsm_state
);

   localparam logic [1:0] SYNC    = 2'd0;
   localparam logic [1:0] CAPTURE = 2'd1;
   localparam logic [1:0] CLOSE   = 2'd2;

   localparam int COL_W = $clog2(IMG_W + 1);
   localparam int ROW_W = $clog2(IMG_H + 1);

   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0]  ROW_END  = ROW_W'(IMG_H);
   localparam logic [ADDR_W-1:0] PTR_MAX  = ADDR_W'((IMG_W / DECIM) * (IMG_H / DECIM) - 1);

   logic [1:0]        state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d, col_base;
   logic [ROW_W-1:0]  row_q, row_d, row_base;
   logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_base;
   logic              ovr_q, ovr_d, ovr_base;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [11:0]       wr_data_q, wr_data_d;
   logic              frame_ready_q, frame_ready_d;
   logic              frame_err_q, frame_err_d;
   logic [7:0]        frame_cnt_q, frame_cnt_d;
   logic              pix_en;
   logic              accept;

   always_comb begin
      state_d       = state_q;
      wr_en_d       = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      frame_ready_d = 1'b0;
      frame_err_d   = frame_err_q;
      frame_cnt_d   = frame_cnt_q;
      accept        = 1'b0;

      case (state_q)
         SYNC: begin
            if (frame_done) state_d = CAPTURE;
         end
         CAPTURE: begin
            if (frame_done) state_d = CLOSE;
         end
         CLOSE: begin
            state_d = CAPTURE;
            if (row_q == ROW_END && col_q == '0 && !ovr_q) begin
               frame_ready_d = 1'b1;
               frame_cnt_d   = frame_cnt_q + 8'd1;
            end else begin
               frame_err_d = 1'b1;
            end
         end
         default: state_d = SYNC;
      endcase

      // The CLOSE cycle clears the frame counters, but a pixel arriving in
      // that same cycle already belongs to the next frame.
      if (state_q == CLOSE) begin
         col_base = '0;
         row_base = '0;
         ptr_base = '0;
         ovr_base = 1'b0;
      end else begin
         col_base = col_q;
         row_base = row_q;
         ptr_base = ptr_q;
         ovr_base = ovr_q;
      end

      col_d  = col_base;
      row_d  = row_base;
      ptr_d  = ptr_base;
      ovr_d  = ovr_base;
      pix_en = pixel_valid && (state_q == CAPTURE || state_q == CLOSE);

      if (pix_en) begin
         accept = (DECIM == 1 || (!col_base[0] && !row_base[0]))
                  && (row_base < ROW_END) && (ptr_base <= PTR_MAX);
         if (row_base >= ROW_END) ovr_d = 1'b1;
         if (accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_base;
            wr_data_d = pixel_data;
            ptr_d     = ptr_base + ADDR_W'(1);
         end
         // Row saturates at IMG_H; anything beyond is already an overrun.
         if (col_base == COL_LAST) begin
            col_d = '0;
            if (row_base != ROW_END) row_d = row_base + ROW_W'(1);
         end else begin
            col_d = col_base + COL_W'(1);
         end
      end
   end

   always_ff @(posedge p_clock) begin
      if (rst) begin
         state_q       <= SYNC;
         col_q         <= '0;
         row_q         <= '0;
         ptr_q         <= '0;
         ovr_q         <= 1'b0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         frame_ready_q <= 1'b0;
         frame_err_q   <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         col_q         <= col_d;
         row_q         <= row_d;
         ptr_q         <= ptr_d;
         ovr_q         <= ovr_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         frame_ready_q <= frame_ready_d;
         frame_err_q   <= frame_err_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign frame_ready = frame_ready_q;
   assign frame_err   = frame_err_q;
   assign frame_cnt   = frame_cnt_q;
   assign fsm_state   = state_q;

endmodule

// File: tb/tb_bram_frame_writer.sv
// Directed bench for bram_frame_writer on a 4x4 image with 2x subsampling;
// a negedge scoreboard checks every BRAM write against an expected queue.
module tb_bram_frame_writer;

   localparam int ADDR_W = 17;
   localparam int W      = ADDR_W + 12;

   logic              p_clock = 1'b0;
   logic              rst = 1'b1;
   logic [11:0]       pixel_data = '0;
   logic              pixel_valid = 1'b0;
   logic              frame_done = 1'b0;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [11:0]       wr_data;
   logic              frame_ready;
   logic              frame_err;
   logic [7:0]        frame_cnt;
   logic [1:0]        fsm_state;

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];

   bram_frame_writer #(.IMG_W(4), .IMG_H(4), .DECIM(2), .ADDR_W(ADDR_W)) dut (
      .p_clock(p_clock), .rst(rst), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
      .frame_done(frame_done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .frame_ready(frame_ready), .frame_err(frame_err), .frame_cnt(frame_cnt),
      .fsm_state(fsm_state)
   );

   always #5 p_clock = ~p_clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Scoreboard: every write strobe must match the head of the expected queue.
   always @(negedge p_clock) begin
      if (wr_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected actual addr=%0d data=0x%03h required=no write", wr_addr, wr_data);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            chk("sb_write", 32'({wr_addr, wr_data}), 32'(e));
         end
         chk("addr_max", 32'(wr_addr <= 3), 32'(1));
      end
   end

   task automatic step(input logic pv, input logic [11:0] pd, input logic fd);
      pixel_valid = pv;
      pixel_data  = pd;
      frame_done  = fd;
      @(posedge p_clock);
      #1;
      pixel_valid = 1'b0;
      frame_done  = 1'b0;
   endtask

   // Hand-computed 4x4/2 mapping: pixels 0,2,8,10 land at addresses 0..3.
   function automatic int addr_of(input int i);
      case (i)
         0:       return 0;
         2:       return 1;
         8:       return 2;
         10:      return 3;
         default: return -1;
      endcase
   endfunction

   task automatic send_pixels(input int first, input int n, input logic [11:0] base, input bit wr_ok);
      for (int i = first; i < first + n; i++) begin
         logic [11:0] d;
         bit w;
         d = 12'(base + 12'(i));
         w = wr_ok && addr_of(i) >= 0;
         if (w) exp_q.push_back({ADDR_W'(addr_of(i)), d});
         step(1'b1, d, 1'b0);
         chk("wr_en_timing", 32'(wr_en), 32'(w));
         chk("no_ready_mid", 32'(frame_ready), 32'(0));
      end
   endtask

   task automatic close_frame(input bit rdy);
      step(1'b0, 12'h000, 1'b1);
      chk("close_state", 32'(fsm_state), 32'(2));
      chk("ready_early", 32'(frame_ready), 32'(0));
      step(1'b0, 12'h000, 1'b0);
      chk("frame_ready", 32'(frame_ready), 32'(rdy));
      step(1'b0, 12'h000, 1'b0);
      chk("ready_one_cycle", 32'(frame_ready), 32'(0));
   endtask

   task automatic check_reset_outputs();
      chk("rst_wr_en", 32'(wr_en), 32'(0));
      chk("rst_wr_addr", 32'(wr_addr), 32'(0));
      chk("rst_wr_data", 32'(wr_data), 32'(0));
      chk("rst_ready", 32'(frame_ready), 32'(0));
      chk("rst_err", 32'(frame_err), 32'(0));
      chk("rst_cnt", 32'(frame_cnt), 32'(0));
      chk("rst_state", 32'(fsm_state), 32'(0));
   endtask

   typedef struct {
      logic        pv;
      logic [11:0] pd;
      logic        fd;
      logic        exp_wr;
      logic [16:0] exp_addr;
      logic [11:0] exp_data;
      logic        exp_rdy;
   } vec_t;

   vec_t tbl[19];

   initial begin
      // Good frame: 16 pixels with data 0x000..0x00F, frame_done, two idle cycles.
      for (int i = 0; i < 16; i++) begin
         tbl[i] = '{1'b1, 12'(i), 1'b0, 1'b0, 17'd0, 12'h000, 1'b0};
      end
      tbl[0].exp_wr  = 1'b1; tbl[0].exp_addr  = 17'd0; tbl[0].exp_data  = 12'h000;
      tbl[2].exp_wr  = 1'b1; tbl[2].exp_addr  = 17'd1; tbl[2].exp_data  = 12'h002;
      tbl[8].exp_wr  = 1'b1; tbl[8].exp_addr  = 17'd2; tbl[8].exp_data  = 12'h008;
      tbl[10].exp_wr = 1'b1; tbl[10].exp_addr = 17'd3; tbl[10].exp_data = 12'h00A;
      tbl[16] = '{1'b0, 12'h000, 1'b1, 1'b0, 17'd0, 12'h000, 1'b0};
      tbl[17] = '{1'b0, 12'h000, 1'b0, 1'b0, 17'd0, 12'h000, 1'b1};
      tbl[18] = '{1'b0, 12'h000, 1'b0, 1'b0, 17'd0, 12'h000, 1'b0};

      // Reset
      rst = 1'b1;
      @(posedge p_clock);
      #1;
      @(posedge p_clock);
      #1;
      check_reset_outputs();
      rst = 1'b0;

      // Sync gating: a whole frame right after reset is ignored.
      send_pixels(0, 16, 12'h0F0, 1'b0);
      step(1'b0, 12'h000, 1'b1);
      chk("sync_to_capture", 32'(fsm_state), 32'(1));

      // Good frame, table driven.
      for (int v = 0; v < 19; v++) begin
         if (tbl[v].exp_wr) exp_q.push_back({tbl[v].exp_addr, tbl[v].exp_data});
         step(tbl[v].pv, tbl[v].pd, tbl[v].fd);
         chk("tbl_wr_en", 32'(wr_en), 32'(tbl[v].exp_wr));
         chk("tbl_ready", 32'(frame_ready), 32'(tbl[v].exp_rdy));
      end
      chk("good_cnt", 32'(frame_cnt), 32'(1));
      chk("good_err", 32'(frame_err), 32'(0));

      // Long frame: 18 pixels, still only four writes.
      send_pixels(0, 18, 12'h300, 1'b1);
      close_frame(1'b0);
      chk("long_err", 32'(frame_err), 32'(1));
      chk("long_cnt", 32'(frame_cnt), 32'(1));

      // Mid-frame reset after pixel 6.
      send_pixels(0, 6, 12'h600, 1'b1);
      rst = 1'b1;
      step(1'b0, 12'h000, 1'b0);
      check_reset_outputs();
      rst = 1'b0;
      send_pixels(0, 16, 12'h700, 1'b0);
      step(1'b0, 12'h000, 1'b1);
      chk("rst_sync_capture", 32'(fsm_state), 32'(1));
      send_pixels(0, 16, 12'h800, 1'b1);
      close_frame(1'b1);
      chk("after_rst_cnt", 32'(frame_cnt), 32'(1));
      chk("after_rst_err", 32'(frame_err), 32'(0));

      // Short frame, then a good frame restarting at address 0.
      send_pixels(0, 15, 12'h900, 1'b1);
      close_frame(1'b0);
      chk("short_err", 32'(frame_err), 32'(1));
      chk("short_cnt", 32'(frame_cnt), 32'(1));
      send_pixels(0, 16, 12'hA00, 1'b1);
      close_frame(1'b1);
      chk("recover_cnt", 32'(frame_cnt), 32'(2));
      chk("err_sticky", 32'(frame_err), 32'(1));

      // Simultaneous events: 16th pixel with frame_done, pixel in CLOSE cycle.
      send_pixels(0, 15, 12'hB00, 1'b1);
      step(1'b1, 12'hB0F, 1'b1);
      chk("sim_last_no_wr", 32'(wr_en), 32'(0));
      chk("sim_close_state", 32'(fsm_state), 32'(2));
      exp_q.push_back({ADDR_W'(0), 12'hBAA});
      step(1'b1, 12'hBAA, 1'b0);
      chk("sim_wr_en", 32'(wr_en), 32'(1));
      chk("sim_ready", 32'(frame_ready), 32'(1));
      chk("sim_cnt", 32'(frame_cnt), 32'(3));
      send_pixels(1, 15, 12'hC00, 1'b1);
      close_frame(1'b1);
      chk("sim_next_cnt", 32'(frame_cnt), 32'(4));

      repeat (2) step(1'b0, 12'h000, 1'b0);
      chk("sb_drain", 32'(exp_q.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bram_frame_writer.md
BRAM_FRAME_WRITER -- requirements
Module: bram_frame_writer

Interface
REQ-001 The module SHALL have parameter IMG_W, default 640, meaning active pixels per input line.
REQ-002 The module SHALL have parameter IMG_H, default 480, meaning active lines per input frame.
REQ-003 The module SHALL have parameter DECIM, default 2, meaning the subsample factor in each axis; the legal values are 1 and 2.
REQ-004 The module SHALL have parameter ADDR_W, default 17, meaning the BRAM address width; it SHALL be at least ceil(log2((IMG_W/DECIM)*(IMG_H/DECIM))).
REQ-005 p_clock  in  1  pixel clock; this is the only clock; all logic SHALL be on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 pixel_data  in  12  RGB444 pixel from the upstream camera capture stage.
REQ-008 pixel_valid  in  1  qualifies pixel_data for exactly one cycle per pixel.
REQ-009 frame_done  in  1  one-cycle pulse at the end of an upstream frame.
REQ-010 wr_en  out  1  BRAM write strobe.
REQ-011 wr_addr  out  ADDR_W  BRAM write address.
REQ-012 wr_data  out  12  BRAM write data.
REQ-013 frame_ready  out  1  one-cycle pulse when a complete, correctly sized frame has been written.
REQ-014 frame_err  out  1  sticky flag for a short or long frame; it SHALL be cleared only by rst.
REQ-015 frame_cnt  out  8  count of completed good frames; it SHALL wrap from 255 to 0.

Function
REQ-016 The FSM states SHALL be SYNC, CAPTURE and CLOSE.
REQ-017 The FSM SHALL enter SYNC on rst.
- In SYNC, all pixels SHALL be ignored.
- frame_done in SYNC SHALL move the FSM to CAPTURE, so that partial frames after reset are never written.
REQ-018 In CAPTURE, each pixel_valid SHALL advance col; col SHALL wrap from IMG_W-1 to 0 and then increment row.
REQ-019 In CAPTURE, a pixel SHALL be accepted for write only when all of the following hold:
- (DECIM==1) or (col[0]==0 and row[0]==0);
- row < IMG_H.
REQ-020 An accepted pixel SHALL produce, exactly one cycle after its pixel_valid:
- wr_en=1;
- wr_data equal to the pixel_data of that pixel;
- wr_addr equal to the current write pointer.
The write pointer SHALL then increment by 1.
REQ-021 wr_en SHALL be 0 in every cycle not described by REQ-020; wr_addr and wr_data SHALL hold their last values when wr_en=0.
REQ-022 A pixel_valid with row >= IMG_H SHALL NOT write, SHALL set an internal overrun flag, and SHALL NOT advance the write pointer.
REQ-023 frame_done in CAPTURE SHALL move the FSM to CLOSE for exactly one cycle, then return it to CAPTURE.
REQ-024 In CLOSE, if row==IMG_H, col==0 and overrun==0, the module SHALL:
- pulse frame_ready for one cycle;
- increment frame_cnt.
Otherwise it SHALL set frame_err=1 and SHALL NOT pulse frame_ready.
REQ-025 In CLOSE, col, row, the write pointer and overrun SHALL be cleared to 0.
REQ-026 If pixel_valid and frame_done are both high in the same cycle, the pixel SHALL be processed first and counted in the closing frame.
REQ-027 A pixel_valid during the CLOSE cycle SHALL be treated as pixel 0 of the next frame: it SHALL be written to address 0 when accepted, and the counters SHALL reflect it.
REQ-028 The maximum write pointer value SHALL be (IMG_W/DECIM)*(IMG_H/DECIM)-1; no write SHALL ever exceed it.
REQ-029 The module SHALL have no backpressure; the BRAM write port is assumed always ready.

Reset
REQ-030 When rst is asserted, the following SHALL hold on the next edge:
- wr_en=0, wr_addr=0, wr_data=0;
- frame_ready=0, frame_err=0, frame_cnt=0;
- col=0, row=0, pointer=0, overrun=0;
- state=SYNC.
REQ-031 A rst asserted mid-frame SHALL abort the frame with no frame_ready and no further writes until a frame_done has been seen in SYNC.

Verification
REQ-032 The bench SHALL run with IMG_W=4, IMG_H=4, DECIM=2 and cover these scenarios:
- Sync gating: 16 pixels, then frame_done, immediately after reset -> no wr_en; FSM in CAPTURE afterwards.
- Good frame: 16 pixels with data 0x000..0x00F, then frame_done -> 4 writes: (addr0,0x000), (addr1,0x002), (addr2,0x008), (addr3,0x00A); each write 1 cycle after its pixel_valid; frame_ready pulse; frame_cnt=1; frame_err=0.
- Short frame: 15 pixels, then frame_done -> frame_err=1; no frame_ready; frame_cnt unchanged; the next 16-pixel frame writes from addr0 and pulses frame_ready.
- Long frame: 18 pixels, then frame_done -> 4 writes only; addr never >3; frame_err=1; no frame_ready.
- Simultaneous events: 16th pixel_valid in the same cycle as frame_done -> frame_ready pulse; a pixel_valid on the following cycle is written to addr0.
- Mid-frame reset: rst after pixel 6 -> all outputs 0 next cycle; the next frame is ignored; the frame after it writes normally.
